gate_trio_unit: RTL and testbench



---
 rtl/gate_trio_unit.sv | 94 +++++++++
 tb/tb_gate_trio_unit.sv | 134 +++++++++++++
 2 files changed

// File: rtl/gate_trio_unit.sv
// Registered bitwise AND/OR/NOT unit built from per-bit leaf gate cells.
// Optional XOR result and port are enabled by defining GATE_XOR_EN.

module and_gate (
  input  logic A,
  input  logic B,
  output logic Y
);
  assign Y = A & B;
endmodule

module or_gate (
  input  logic A,
  input  logic B,
  output logic Y
);
  assign Y = A | B;
endmodule

module not_gate (
  input  logic A,
  output logic Y
);
  assign Y = ~A;
endmodule

`ifdef GATE_XOR_EN
module xor_gate (
  input  logic A,
  input  logic B,
  output logic Y
);
  assign Y = A ^ B;
endmodule
`endif

module gate_trio_unit #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y_and,
  output logic [WIDTH-1:0] y_or,
  output logic [WIDTH-1:0] y_not,
`ifdef GATE_XOR_EN
  output logic [WIDTH-1:0] y_xor,
`endif
  output logic             out_valid
);

  logic [WIDTH-1:0] and_bits;
  logic [WIDTH-1:0] or_bits;
  logic [WIDTH-1:0] not_bits;
`ifdef GATE_XOR_EN
  logic [WIDTH-1:0] xor_bits;
`endif

  // One leaf of each kind per bit; bits never interact.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    and_gate u_and (.A(a[i]), .B(b[i]), .Y(and_bits[i]));
    or_gate  u_or  (.A(a[i]), .B(b[i]), .Y(or_bits[i]));
    not_gate u_not (.A(a[i]),           .Y(not_bits[i]));
`ifdef GATE_XOR_EN
    xor_gate u_xor (.A(a[i]), .B(b[i]), .Y(xor_bits[i]));
`endif
  end

  // Result registers: reset clears all (y_not included), capture on in_valid, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_and     <= {WIDTH{1'b0}};
      y_or      <= {WIDTH{1'b0}};
      y_not     <= {WIDTH{1'b0}};
`ifdef GATE_XOR_EN
      y_xor     <= {WIDTH{1'b0}};
`endif
      out_valid <= 1'b0;
    end else if (in_valid) begin
      y_and     <= and_bits;
      y_or      <= or_bits;
      y_not     <= not_bits;
`ifdef GATE_XOR_EN
      y_xor     <= xor_bits;
`endif
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gate_trio_unit.sv
// Scoreboard bench for gate_trio_unit at WIDTH=8; checks y_xor when GATE_XOR_EN is defined.

module tb_gate_trio_unit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_valid = 1'b0;
  logic [W-1:0] y_and, y_or, y_not;
`ifdef GATE_XOR_EN
  logic [W-1:0] y_xor;
`endif
  logic         out_valid;

  gate_trio_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
    .y_and(y_and), .y_or(y_or), .y_not(y_not),
`ifdef GATE_XOR_EN
    .y_xor(y_xor),
`endif
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] e_and;
    logic [W-1:0] e_or;
    logic [W-1:0] e_not;
    logic [W-1:0] e_xor;
    logic         e_valid;
  } exp_t;

  exp_t exp_q[$];
  exp_t model;
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive one cycle, advance the reference model, then compare after the edge.
  task automatic step(input logic r, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic v, input string tag);
    exp_t e;
    @(negedge clk);
    rst = r; a = av; b = bv; in_valid = v;
    if (r) begin
      model = '0;
    end else if (v) begin
      model.e_and = av & bv;
      model.e_or = av | bv;
      model.e_not = ~av;
      model.e_xor = av ^ bv;
      model.e_valid = 1'b1;
    end else begin
      model.e_valid = 1'b0;
    end
    exp_q.push_back(model);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_queue"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, "_and"}, 64'(y_and), 64'(e.e_and));
      check_eq({tag, "_or"}, 64'(y_or), 64'(e.e_or));
      check_eq({tag, "_not"}, 64'(y_not), 64'(e.e_not));
`ifdef GATE_XOR_EN
      check_eq({tag, "_xor"}, 64'(y_xor), 64'(e.e_xor));
`endif
      check_eq({tag, "_valid"}, 64'(out_valid), 64'(e.e_valid));
    end
  endtask

  initial begin
    logic [1:0] ab;
    model = '0;

    // Reset held with live inputs: nothing captured.
    step(1'b1, 8'hFF, 8'hFF, 1'b1, "rst0");
    step(1'b1, 8'hFF, 8'hFF, 1'b1, "rst1");
    step(1'b0, 8'hFF, 8'hFF, 1'b0, "idle");

    // Truth table, each pattern replicated across all bits.
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      step(1'b0, {W{ab[1]}}, {W{ab[0]}}, 1'b1, "tt");
    end
    // Constant truth-table expectations independent of the model.
    check_eq("tt11_and", 64'(y_and), 64'hFF);
    check_eq("tt11_not", 64'(y_not), 64'h00);

    // Hold: capture a=1,b=0 then drop in_valid and change inputs.
    step(1'b0, 8'h01, 8'h00, 1'b1, "cap");
    step(1'b0, 8'h00, 8'h01, 1'b0, "hold");
    check_eq("hold_or_lit", 64'(y_or), 64'h01);
    check_eq("hold_not_lit", 64'(y_not), 64'hFE);

    // Wide bitwise pattern.
    step(1'b0, 8'hA5, 8'h3C, 1'b1, "wide");
    check_eq("wide_and_lit", 64'(y_and), 64'h24);
    check_eq("wide_or_lit", 64'(y_or), 64'hBD);
    check_eq("wide_not_lit", 64'(y_not), 64'h5A);
`ifdef GATE_XOR_EN
    check_eq("wide_xor_lit", 64'(y_xor), 64'h99);
`endif

    // Mid-stream reset on the 3rd of 4 back-to-back inputs.
    step(1'b0, 8'h12, 8'h34, 1'b1, "ms1");
    step(1'b0, 8'h56, 8'h78, 1'b1, "ms2");
    step(1'b1, 8'h9A, 8'hBC, 1'b1, "ms3");
    step(1'b0, 8'hDE, 8'hF0, 1'b1, "ms4");
    check_eq("ms4_and_lit", 64'(y_and), 64'hD0);

    // Random stream with sparse resets.
    for (int i = 0; i < 40; i++) begin
      step(($urandom_range(0, 9) == 0), 8'($urandom), 8'($urandom),
           ($urandom_range(0, 3) != 0), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
